fetch_unit: RTL and testbench

- Instruction fetch stage for the multicycle MIPS core; produces the instruction word whose op/funct fields feed the controller.
- Consumes the controller's branch/jump/jumpr results to compute the next PC.
- Talks to instruction memory over a req/ack handshake.
- Holds one instruction for decode under a valid/ready handshake.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/next_pc_calc.sv | 37 +++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core.
// Holds the fetch state encoding, instruction field bit positions, the
// opcode constants shared with the main decoder, and the branch-offset helper.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

  // Instruction field bit positions
  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;
  localparam int unsigned JADDR_HI = 25;
  localparam int unsigned JADDR_LO = 0;

  // Opcodes shared with maindec
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // Sign-extended immediate shifted to a byte offset
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for an accepted instruction.
// Ports: pc (address of held instruction), instr (held word), rs_data
// (register-jump target), branch/zero/jump/jumpr (controller results);
// pcplus4 (pc+4, wraps), target (priority jumpr > jump > taken branch > pc+4).
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs_data,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic            jumpr,
  output logic [XLEN-1:0] pcplus4,
  output logic [XLEN-1:0] target
);

  // Opcode and the byte-offset bits of rs_data play no part in the target
  logic unused_bits;
  assign unused_bits = ^{instr[OP_HI:OP_LO], rs_data[1:0]};

  assign pcplus4 = pc + 32'd4;

  // Priority target mux
  always_comb begin
    target = pcplus4;
    if (jumpr) begin
      target = {rs_data[31:2], 2'b00};
    end else if (jump) begin
      target = {pcplus4[31:28], instr[JADDR_HI:JADDR_LO], 2'b00};
    end else if (branch && zero) begin
      target = pcplus4 + branch_offset(instr[IMM_HI:IMM_LO]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word at a time from instruction
// memory (req/ack), holds it for decode (valid/ready) and computes the next
// PC on accept. flush redirects from any state; a flush racing an
// outstanding request discards the late returning word.
// Ports: clk, reset (async active-low); imem_req/imem_addr/imem_ack/
// imem_rdata memory side; instr/op/funct/instr_valid/instr_ready/pcplus4
// decode side; branch/zero/jump/jumpr/rs_data control (used on accept);
// flush/flush_pc redirect.
// Optional macro FETCH_STATS_EN adds fetch_cnt (accepts) and flush_cnt
// (flush cycles) outputs.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pcplus4,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jumpr,
  input  logic [31:0] rs_data,
  input  logic        flush,
  input  logic [31:0] flush_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  addr_nxt;
  logic [31:0]  instr_nxt;
  logic         drop_pend, drop_nxt;
  logic         accept;
  logic         hold_addr;
  logic [31:0]  target;

  logic unused_bits;
  assign unused_bits = ^flush_pc[1:0];

  next_pc_calc u_next_pc (
    .pc      (pc),
    .instr   (instr),
    .rs_data (rs_data),
    .branch  (branch),
    .zero    (zero),
    .jump    (jump),
    .jumpr   (jumpr),
    .pcplus4 (pcplus4),
    .target  (target)
  );

  // Outputs decoded from state / registered instruction
  assign imem_req    = (state == REQ);
  assign instr_valid = (state == VALID);
  assign op          = instr[OP_HI:OP_LO];
  assign funct       = instr[FUNCT_HI:FUNCT_LO];
  assign accept      = (state == VALID) && instr_ready && !flush;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC_AL;
      imem_addr <= RESET_PC_AL;
      instr     <= 32'h0;
      drop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      imem_addr <= addr_nxt;
      instr     <= instr_nxt;
      drop_pend <= drop_nxt;
    end
  end

  // Next-state logic; flush overrides everything at the end
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    drop_nxt  = drop_pend;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ack) begin
          // Any ack answers the outstanding request, so the drop is consumed
          drop_nxt = 1'b0;
          if (!drop_pend && !flush) begin
            instr_nxt = imem_rdata;
            state_nxt = VALID;
          end
        end else if (flush) begin
          drop_nxt = 1'b1;
        end
      end
      VALID: begin
        if (accept) begin
          pc_nxt    = target;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      pc_nxt    = {flush_pc[31:2], 2'b00};
      state_nxt = REQ;
    end
    // The memory still owns the old address until it acks
    hold_addr = (state == REQ) && !imem_ack && (drop_pend || flush);
    addr_nxt  = hold_addr ? imem_addr : pc_nxt;
  end

`ifdef FETCH_STATS_EN
  // Event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (accept) fetch_cnt <= fetch_cnt + 32'd1;
      if (flush)  flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of held-word/control vectors with
// literal expected next addresses, a scoreboard queue of expected instruction
// words, and hand-written reset, flush-race and wrap sequences.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pcplus4;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic        jumpr = 1'b0;
  logic [31:0] rs_data = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pcplus4     (pcplus4),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jumpr       (jumpr),
    .rs_data     (rs_data),
    .flush       (flush),
    .flush_pc    (flush_pc)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] word;
    logic        br, zr, jp, jr;
    logic [31:0] rs;
    logic [31:0] exp_p4;
    logic [31:0] exp_next;
    int          dly;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int exp_accepts = 0;
  int exp_flushes = 0;
  logic [31:0] sb[$];
  vec_t vecs[10];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Control inputs are noise outside the accept cycle
  task automatic noise_ctl();
    branch      = 1'($urandom);
    zero        = 1'($urandom);
    jump        = 1'($urandom);
    jumpr       = 1'($urandom);
    rs_data     = $urandom;
    instr_ready = 1'($urandom);
  endtask

  task automatic quiet_ctl();
    branch = 1'b0; zero = 1'b0; jump = 1'b0; jumpr = 1'b0;
    rs_data = 32'h0; instr_ready = 1'b0;
  endtask

  // DUT in VALID: pop the scoreboard and compare the held word
  task automatic observe_valid(input logic [31:0] exp_p4);
    logic [31:0] w;
    check32("instr_valid", 32'(instr_valid), 32'd1);
    check32("imem_req_in_valid", 32'(imem_req), 32'd0);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got valid instr %h want none", instr);
    end else begin
      w = sb.pop_front();
      check32("instr", instr, w);
      check32("op", 32'(op), 32'(w[31:26]));
      check32("funct", 32'(funct), 32'(w[5:0]));
    end
    check32("pcplus4", pcplus4, exp_p4);
  endtask

  // DUT in REQ at addr: wait dly cycles, then ack with word; ends in VALID
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                       input int dly, input logic [31:0] exp_p4);
    for (int k = 0; k < dly; k++) begin
      imem_ack = 1'b0;
      noise_ctl();
      @(negedge clk);
      check32("req_stable", 32'(imem_req), 32'd1);
      check32("addr_stable", imem_addr, addr);
    end
    check32("fetch_addr", imem_addr, addr);
    noise_ctl();
    imem_ack = 1'b1;
    imem_rdata = word;
    sb.push_back(word);
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    quiet_ctl();
    observe_valid(exp_p4);
    // One stall cycle: hold must persist with noisy controls
    noise_ctl();
    instr_ready = 1'b0;
    @(negedge clk);
    check32("hold_valid", 32'(instr_valid), 32'd1);
    check32("hold_instr", instr, word);
  endtask

  task automatic do_accept(input logic br, input logic zr, input logic jp,
                           input logic jr, input logic [31:0] rs,
                           input logic [31:0] exp_next);
    branch = br; zero = zr; jump = jp; jumpr = jr; rs_data = rs;
    instr_ready = 1'b1;
    exp_accepts++;
    @(negedge clk);
    quiet_ctl();
    check32("post_accept_req", 32'(imem_req), 32'd1);
    check32("post_accept_valid", 32'(instr_valid), 32'd0);
    check32("next_addr", imem_addr, exp_next);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0040, 32'h1000_FFFF, 1, 1, 0, 0, 32'h0, 32'h0000_0044, 32'h0000_0040, 0};
    vecs[1] = '{32'h0000_0040, 32'h1000_FFFF, 1, 0, 0, 0, 32'h0, 32'h0000_0044, 32'h0000_0044, 1};
    vecs[2] = '{32'h0000_1000, 32'h0800_0010, 0, 0, 1, 0, 32'h0, 32'h0000_1004, 32'h0000_0040, 2};
    vecs[3] = '{32'h0000_1000, 32'h0800_0010, 0, 0, 1, 1, 32'h203, 32'h0000_1004, 32'h0000_0200, 0};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0020, 0, 0, 0, 0, 32'h0, 32'h0000_0000, 32'h0000_0000, 3};
    vecs[5] = '{32'h0000_0100, 32'h1000_0003, 1, 1, 0, 0, 32'h0, 32'h0000_0104, 32'h0000_0110, 1};
    vecs[6] = '{32'hFFFF_FFF0, 32'h1000_0004, 1, 1, 0, 0, 32'h0, 32'hFFFF_FFF4, 32'h0000_0004, 0};
    vecs[7] = '{32'h0000_0200, 32'h1000_0010, 0, 1, 0, 0, 32'h0, 32'h0000_0204, 32'h0000_0204, 2};
    vecs[8] = '{32'hF000_0000, 32'h0BFF_FFFF, 1, 1, 1, 0, 32'h0, 32'hF000_0004, 32'hFFFF_FFFC, 1};
    vecs[9] = '{32'h0000_3000, 32'h0000_0008, 1, 1, 1, 1, 32'h1234_5677, 32'h0000_3004, 32'h1234_5674, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check32("rst_req", 32'(imem_req), 32'd0);
    check32("rst_valid", 32'(instr_valid), 32'd0);
    check32("rst_instr", instr, 32'h0);
    check32("rst_addr", imem_addr, RST_PC);

    // Release, immediate ack of first fetch
    reset = 1'b1;
    @(negedge clk);
    check32("first_req", 32'(imem_req), 32'd1);
    check32("first_valid_low", 32'(instr_valid), 32'd0);
    fetch(RST_PC, 32'h2008_0005, 0, 32'h0000_0004);
    check32("first_op", 32'(op), 32'h08);
    do_accept(0, 0, 0, 0, 32'h0, 32'h0000_0004);

    // Vector table: redirect by flush racing an ack, fetch, accept
    for (int i = 0; i < 10; i++) begin
      flush = 1'b1;
      flush_pc = vecs[i].start_pc | 32'(i & 3);
      imem_ack = 1'b1;
      imem_rdata = 32'hBAD0_0000 | 32'(i);
      exp_flushes++;
      @(negedge clk);
      flush = 1'b0;
      imem_ack = 1'b0;
      check32("redir_req", 32'(imem_req), 32'd1);
      check32("redir_valid", 32'(instr_valid), 32'd0);
      check32("redir_addr", imem_addr, vecs[i].start_pc);
      fetch(vecs[i].start_pc, vecs[i].word, vecs[i].dly, vecs[i].exp_p4);
      do_accept(vecs[i].br, vecs[i].zr, vecs[i].jp, vecs[i].jr, vecs[i].rs,
                vecs[i].exp_next);
    end

    // Flush with request outstanding; late ack must be dropped
    begin
      logic [31:0] old_addr;
`ifdef FETCH_STATS_EN
      logic [31:0] fc0;
      fc0 = flush_cnt;
`endif
      old_addr = imem_addr;
      flush = 1'b1;
      flush_pc = 32'h0000_0080;
      exp_flushes++;
      @(negedge clk);
      flush = 1'b0;
      check32("drop_old_addr1", imem_addr, old_addr);
      check32("drop_req1", 32'(imem_req), 32'd1);
      @(negedge clk);
      check32("drop_old_addr2", imem_addr, old_addr);
      @(negedge clk);
      check32("drop_old_addr3", imem_addr, old_addr);
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack = 1'b0;
      check32("drop_valid", 32'(instr_valid), 32'd0);
      check32("drop_req2", 32'(imem_req), 32'd1);
      check32("drop_new_addr", imem_addr, 32'h0000_0080);
      checks++;
      if (instr === 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL drop_data: got %h want anything else", instr);
      end
`ifdef FETCH_STATS_EN
      check32("flush_cnt_delta", flush_cnt - fc0, 32'd1);
`endif
      fetch(32'h0000_0080, 32'h8C48_0004, 2, 32'h0000_0084);
      do_accept(0, 0, 0, 0, 32'h0, 32'h0000_0084);
`ifdef FETCH_STATS_EN
      check32("fetch_cnt", fetch_cnt, 32'(exp_accepts));
      check32("flush_cnt", flush_cnt, 32'(exp_flushes));
`endif
    end

    // Asynchronous reset mid-REQ
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check32("async_rst_req", 32'(imem_req), 32'd0);
    check32("async_rst_valid", 32'(instr_valid), 32'd0);
    check32("async_rst_addr", imem_addr, RST_PC);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check32("restart_req", 32'(imem_req), 32'd1);
    check32("restart_addr", imem_addr, RST_PC);
    fetch(RST_PC, 32'h0000_0020, 1, 32'h0000_0004);
    do_accept(0, 0, 0, 0, 32'h0, 32'h0000_0004);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
